usb1d_tx_phy: RTL and testbench



---
 rtl/usb1d_pkg.sv | 30 +++
 rtl/usb1d_bit_tick.sv | 37 +++
 rtl/usb1d_tx_phy.sv | 192 +++++++++++++++++++
 tb/tb_usb1d_tx_phy.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb1d_pkg.sv
// usb1d_pkg: shared definitions for the USB1 device transmit path.
//   tx_state_e  - transmit FSM state encoding (3 bits, also exported as debug)
//   USB_SYNC    - SYNC pattern, sent LSB first
//   LINE_*      - {dp, dn} drive values for J, K and SE0
//   STUFF_LIMIT - consecutive ones that force a stuff bit
package usb1d_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StSync = 3'd1,
        StData = 3'd2,
        StEop1 = 3'd3,
        StEop2 = 3'd4,
        StEop3 = 3'd5
    } tx_state_e;

    localparam logic [7:0] USB_SYNC = 8'h80;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int unsigned STUFF_LIMIT = 6;

    // NRZI level 1 is J, 0 is K.
    function automatic logic [1:0] nrzi_line(input logic level);
        return level ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/usb1d_bit_tick.sv
// usb1d_bit_tick: free-running modulo-CLK_DIV counter marking USB bit periods.
//   clk      in  core clock
//   rst_n    in  asynchronous active-low reset
//   clr      in  synchronous clear; the next cycle is the first of a bit period
//   bit_tick out high on the last clk of each bit period
module usb1d_bit_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_tick
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clr || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == CntMax);

endmodule

// File: rtl/usb1d_tx_phy.sv
// usb1d_tx_phy: full-speed USB transmit serializer.
// Takes the packet assembler's byte stream and drives the line with SYNC,
// LSB-first data, bit stuffing, NRZI encoding and a SE0 SE0 J end-of-packet.
//   clk      in  core clock, CLK_DIV x 12 MHz
//   rst_n    in  asynchronous active-low reset
//   tx_data  in  byte to transmit, consumed at a byte boundary
//   tx_valid in  packet in progress; checked in IDLE and at byte boundaries only
//   tx_ready out one-clk pulse: tx_data taken, present the next byte
//   txdp     out D+ drive (registered)
//   txdn     out D- drive (registered)
//   txoe_n   out output enable, active low (registered)
//   busy     out high whenever the FSM is not idle
//   state    out debug copy of the FSM state
module usb1d_tx_phy
    import usb1d_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txdp,
    output logic       txdn,
    output logic       txoe_n,
    output logic       busy,
    output logic [2:0] state
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;     // current byte, bit 0 is on the line
    logic [2:0] bit_idx_q, bit_idx_d; // index of the data bit on the line
    logic [2:0] ones_q, ones_d;       // consecutive ones sent so far
    logic       stuff_q, stuff_d;     // current bit period is a stuff bit
    logic       nrzi_q, nrzi_d;       // NRZI level, 1 = J
    logic [1:0] line_q, line_d;
    logic       oe_n_q, oe_n_d;
    logic       ready_q, ready_d;

    logic       bit_tick;
    logic       tick_clr;
    logic       cur_bit;
    logic [2:0] ones_inc;
    logic       need_stuff;
    logic       byte_end;
    logic [7:0] next_shift;

    // Re-anchor bit timing to the edge that enters SYNC.
    assign tick_clr = (state_q == StIdle) && tx_valid;

    usb1d_bit_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tick_clr),
        .bit_tick (bit_tick)
    );

    always_comb begin
        cur_bit    = shift_q[0];
        ones_inc   = ones_q + 3'd1;
        need_stuff = !stuff_q && cur_bit && (ones_inc == 3'(STUFF_LIMIT));
        // A stuff bit following bit 7 leaves bit_idx wrapped to 0; no stuff bit
        // can otherwise occur with bit_idx 0, so that marks a deferred boundary.
        byte_end   = stuff_q ? (bit_idx_q == 3'd0) : ((bit_idx_q == 3'd7) && !need_stuff);
        // The register shifts when a data bit ends and holds across a stuff bit.
        next_shift = stuff_q ? shift_q : {1'b0, shift_q[7:1]};
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        ones_d    = ones_q;
        stuff_d   = stuff_q;
        nrzi_d    = nrzi_q;
        line_d    = line_q;
        oe_n_d    = oe_n_q;
        ready_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    state_d   = StSync;
                    shift_d   = USB_SYNC;
                    bit_idx_d = 3'd0;
                    ones_d    = 3'd0;
                    stuff_d   = 1'b0;
                    // NRZI starts from J, so the first level equals the first bit.
                    nrzi_d    = USB_SYNC[0];
                    line_d    = nrzi_line(USB_SYNC[0]);
                    oe_n_d    = 1'b0;
                end
            end

            StSync, StData: begin
                if (bit_tick) begin
                    if (!stuff_q) begin
                        shift_d   = next_shift;
                        ones_d    = cur_bit ? ones_inc : 3'd0;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end

                    if (need_stuff) begin
                        stuff_d = 1'b1;
                        ones_d  = 3'd0;
                        nrzi_d  = ~nrzi_q;
                        line_d  = nrzi_line(~nrzi_q);
                    end else if (byte_end) begin
                        stuff_d = 1'b0;
                        if (tx_valid) begin
                            state_d   = StData;
                            ready_d   = 1'b1;
                            shift_d   = tx_data;
                            bit_idx_d = 3'd0;
                            nrzi_d    = tx_data[0] ? nrzi_q : ~nrzi_q;
                            line_d    = nrzi_line(tx_data[0] ? nrzi_q : ~nrzi_q);
                        end else begin
                            state_d = StEop1;
                            line_d  = LINE_SE0;
                        end
                    end else begin
                        stuff_d = 1'b0;
                        nrzi_d  = next_shift[0] ? nrzi_q : ~nrzi_q;
                        line_d  = nrzi_line(next_shift[0] ? nrzi_q : ~nrzi_q);
                    end
                end
            end

            StEop1: begin
                if (bit_tick) begin
                    state_d = StEop2;
                end
            end

            StEop2: begin
                if (bit_tick) begin
                    state_d = StEop3;
                    line_d  = LINE_J;
                end
            end

            StEop3: begin
                if (bit_tick) begin
                    state_d = StIdle;
                    nrzi_d  = 1'b1;
                    oe_n_d  = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                nrzi_d  = 1'b1;
                line_d  = LINE_J;
                oe_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            ones_q    <= 3'd0;
            stuff_q   <= 1'b0;
            nrzi_q    <= 1'b1;
            line_q    <= LINE_J;
            oe_n_q    <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            ones_q    <= ones_d;
            stuff_q   <= stuff_d;
            nrzi_q    <= nrzi_d;
            line_q    <= line_d;
            oe_n_q    <= oe_n_d;
            ready_q   <= ready_d;
        end
    end

    assign {txdp, txdn} = line_q;
    assign txoe_n       = oe_n_q;
    assign tx_ready     = ready_q;
    assign busy         = (state_q != StIdle);
    assign state        = state_q;

endmodule

// File: tb/tb_usb1d_tx_phy.sv
// tb_usb1d_tx_phy: self-checking bench for usb1d_tx_phy.
// A wire-level model turns each packet's byte list into the expected sequence
// of line symbols and tx_ready times; every clk of the packet is compared.
module tb_usb1d_tx_phy;

    localparam int unsigned CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txdp;
    logic       txdn;
    logic       txoe_n;
    logic       busy;
    logic [2:0] state;

    always #5 clk = ~clk;

    usb1d_tx_phy #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txdp     (txdp),
        .txdn     (txdn),
        .txoe_n   (txoe_n),
        .busy     (busy),
        .state    (state)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] pkt[$];
    logic [1:0] exp_sym[$];
    int         exp_rdy[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Wire model: bit list -> stuffing -> NRZI levels -> symbols, then EOP.
    task automatic build_model();
        logic       level;
        int         ones;
        logic [7:0] b;
        exp_sym.delete();
        exp_rdy.delete();
        level = 1'b1;
        ones  = 0;
        for (int j = 0; j <= pkt.size(); j++) begin
            b = (j == 0) ? 8'h80 : pkt[j-1];
            for (int i = 0; i < 8; i++) begin
                if (b[i] == 1'b0) begin
                    level = !level;
                    ones  = 0;
                end else begin
                    ones++;
                end
                exp_sym.push_back(level ? 2'b10 : 2'b01);
                if (ones == 6) begin
                    level = !level;
                    ones  = 0;
                    exp_sym.push_back(level ? 2'b10 : 2'b01);
                end
            end
            if (j < pkt.size()) exp_rdy.push_back(exp_sym.size() * CLK_DIV);
        end
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b10);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("gap_line", {txdp, txdn, txoe_n}, 3'b101);
            check("gap_busy", {tx_ready, busy}, 2'b00);
        end
    endtask

    // Called at a sampling point with the DUT idle. b2b re-raises tx_valid in
    // EOP1 and leaves it high; abort_at >= 0 resets the DUT at that cycle.
    task automatic run_packet(input int b2b, input int abort_at);
        int   len;
        int   nrdy;
        int   noe;
        int   drop_at;
        logic rdy_exp;
        build_model();
        len     = exp_sym.size() * CLK_DIV;
        nrdy    = 0;
        noe     = 0;
        drop_at = -1;
        tx_data  = pkt[0];
        tx_valid = 1'b1;
        for (int k = 0; k <= len; k++) begin
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                #1;
                rst_n = 1'b0;
                #1;
                check("rst_line", {txdp, txdn, txoe_n}, 3'b101);
                check("rst_ready_busy", {tx_ready, busy}, 2'b00);
                tx_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                check("post_rst_line", {txdp, txdn, txoe_n}, 3'b101);
                return;
            end
            rdy_exp = 1'b0;
            foreach (exp_rdy[i]) if (exp_rdy[i] == k) rdy_exp = 1'b1;
            if (k < len) begin
                check("line", {txdp, txdn, txoe_n}, {exp_sym[k / CLK_DIV], 1'b0});
                check("busy", busy, 1'b1);
            end else begin
                check("end_line", {txdp, txdn, txoe_n}, 3'b101);
                check("end_busy", busy, 1'b0);
            end
            check("ready", tx_ready, rdy_exp);
            nrdy += int'(tx_ready);
            noe  += int'(!txoe_n);
            // Host: hold data until the cycle after the pulse, then advance.
            foreach (exp_rdy[i]) begin
                if (exp_rdy[i] + 1 == k) begin
                    if (i + 1 < pkt.size()) tx_data = pkt[i+1];
                    else drop_at = k + int'($urandom_range(0, 8 * CLK_DIV - 4));
                end
            end
            if (k == drop_at) tx_valid = 1'b0;
            if (b2b != 0 && k == len - 3 * CLK_DIV + 1) tx_valid = 1'b1;
        end
        check("n_ready", nrdy, pkt.size());
        check("oe_len", noe, len);
    endtask

    initial begin
        int   b2b;
        int   prev_b2b;
        logic [7:0] b;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_line", {txdp, txdn, txoe_n}, 3'b101);
        check("reset_ready_busy", {tx_ready, busy}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        idle_gap(3);

        // Single ACK.
        pkt = '{8'hD2};
        run_packet(0, -1);
        idle_gap(2);

        // Stuff bit inside the second byte.
        pkt = '{8'hC3, 8'hFF};
        run_packet(0, -1);
        idle_gap(2);

        // Stuff bit due after the last data bit.
        pkt = '{8'hC3, 8'hFC};
        run_packet(0, -1);
        idle_gap(2);

        // Three bytes, tx_valid dropped mid-byte 3.
        pkt = '{8'hC3, 8'h01, 8'h02};
        run_packet(0, -1);
        idle_gap(2);

        // Reset in the middle of DATA, then restart from SYNC.
        pkt = '{8'hC3, 8'hFF, 8'h00};
        run_packet(0, 50);
        pkt = '{8'hD2};
        run_packet(0, -1);
        idle_gap(1);

        // Back-to-back: tx_valid held through EOP.
        pkt = '{8'hD2};
        run_packet(1, -1);
        pkt = '{8'hC3, 8'hFF};
        run_packet(0, -1);
        idle_gap(1);

        // Random packets, biased towards long runs of ones.
        prev_b2b = 0;
        for (int p = 0; p < 12; p++) begin
            pkt.delete();
            for (int n = 0; n < int'($urandom_range(1, 4)); n++) begin
                b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 2) == 0) b = b | 8'hFC;
                pkt.push_back(b);
            end
            if (prev_b2b == 0) idle_gap(int'($urandom_range(0, 3)));
            b2b = (p < 11) ? int'($urandom_range(0, 1)) : 0;
            run_packet(b2b, -1);
            prev_b2b = b2b;
        end
        idle_gap(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
